// File: rtl/timing_control_unit.sv
// Timing control unit: waits each FIFO trigger word's interval, then pops it with a one-cycle re strobe.
// Optional build macro TCU_COARSE_SCALE_EN enables the x8 interval prescale selected by trigger bit 7.
module timing_control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] trg_wrd,
  input  logic       fifo_empty,
  output logic       re
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FIRE = 2'd2,
    GAP  = 2'd3
  } state_t;

`ifdef TCU_COARSE_SCALE_EN
  localparam int CNT_W = 10;
`else
  localparam int CNT_W = 7;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] cnt_load;
  logic             re_d;

`ifdef TCU_COARSE_SCALE_EN
  function automatic logic [CNT_W-1:0] eff_interval(input logic [6:0] n, input logic coarse);
    return coarse ? {n, 3'b000} : {3'b000, n};
  endfunction

  assign cnt_load = eff_interval(trg_wrd[6:0], trg_wrd[7]);
`else
  // Bit 7 carries no meaning without the prescaler.
  logic unused_coarse;
  assign unused_coarse = trg_wrd[7];
  assign cnt_load      = trg_wrd[6:0];
`endif

  // State register: sync active-low reset returns to IDLE without popping the pending word
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      re    <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      re    <= re_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = WAIT;
          cnt_d   = cnt_load;
        end
      end
      WAIT: begin
        if (cnt != '0) cnt_d = cnt - CNT_ONE;
        else           state_d = FIRE;
      end
      FIRE:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: re is registered so it is high exactly while the state is FIRE
  always_comb begin
    re_d = (state_d == FIRE);
  end

endmodule

// File: tb/tb_timing_control_unit.sv
// Directed self-checking bench for timing_control_unit; build with TCU_COARSE_SCALE_EN to cover the prescaler.
module tb_timing_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] trg_wrd;
  logic       fifo_empty;
  logic       re;

  int checks   = 0;
  int failures = 0;

  int first_pos;
  int pulses;
  int doubles;
  int exp_coarse;

  timing_control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .trg_wrd    (trg_wrd),
    .fifo_empty (fifo_empty),
    .re         (re)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle to the falling edge for sampling and driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs n edges; first is the 1-based edge index after which re was first high (-1 if never).
  task automatic watch(input int n, output int first, output int cnt, output int dbl);
    logic prev;
    prev  = re;
    first = -1;
    cnt   = 0;
    dbl   = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (re === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
        if (prev === 1'b1) dbl++;
      end
      prev = re;
    end
  endtask

  initial begin
`ifdef TCU_COARSE_SCALE_EN
    exp_coarse = 9;
`else
    exp_coarse = 2;
`endif
    rst        = 1'b0;
    fifo_empty = 1'b0;
    trg_wrd    = 8'h03;
    @(negedge clk);

    // Reset held for two edges with a word waiting
    tick();
    check("reset_re_edge1", int'(re), 0);
    tick();
    check("reset_re_edge2", int'(re), 0);
    rst = 1'b1;
    tick();
    check("accept_re", int'(re), 0);

    // Interval 3 with words continuously available: re after edge 4, next accept at edge 7
    watch(7, first_pos, pulses, doubles);
    check("n3_first_pos", first_pos, 4);
    check("n3_pulses", pulses, 1);
    watch(4, first_pos, pulses, doubles);
    check("n3_second_pos", first_pos, 4);
    check("n3_second_pulses", pulses, 1);
    fifo_empty = 1'b1;
    watch(3, first_pos, pulses, doubles);

    // Coarse flag word 0x81
    trg_wrd    = 8'h81;
    fifo_empty = 1'b0;
    tick();
    fifo_empty = 1'b1;
    watch(12, first_pos, pulses, doubles);
    check("coarse_first_pos", first_pos, exp_coarse);
    check("coarse_pulses", pulses, 1);

    // Zero interval stream: pulses every 4 cycles, never two in a row
    trg_wrd    = 8'h00;
    fifo_empty = 1'b0;
    tick();
    watch(16, first_pos, pulses, doubles);
    check("zero_first_pos", first_pos, 1);
    check("zero_pulses", pulses, 4);
    check("zero_doubles", doubles, 0);
    fifo_empty = 1'b1;
    watch(4, first_pos, pulses, doubles);

    // Empty FIFO for 20 cycles with junk on the word bus
    trg_wrd = 8'h55;
    watch(20, first_pos, pulses, doubles);
    check("empty_pulses", pulses, 0);
    trg_wrd    = 8'h02;
    fifo_empty = 1'b0;
    tick();
    trg_wrd    = 8'h7F;
    fifo_empty = 1'b1;
    watch(6, first_pos, pulses, doubles);
    check("n2_first_pos", first_pos, 3);
    check("n2_pulses", pulses, 1);

    // Reset on the 10th WAIT edge; the pending word restarts its full count
    trg_wrd    = 8'h7F;
    fifo_empty = 1'b0;
    tick();
    watch(9, first_pos, pulses, doubles);
    check("midrst_wait_pulses", pulses, 0);
    rst = 1'b0;
    tick();
    check("midrst_re", int'(re), 0);
    rst = 1'b1;
    tick();
    fifo_empty = 1'b1;
    watch(131, first_pos, pulses, doubles);
    check("midrst_restart_pos", first_pos, 128);
    check("midrst_restart_pulses", pulses, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timing_control_unit.md
# timing_control_unit

Timing control unit of the qubit pipeline. It consumes 8-bit timing trigger words from a first-word-fall-through timing FIFO. For each word it waits the encoded number of clock cycles, then pulses the FIFO read enable to release (pop) that word and advance to the next one. The `re` pulse doubles as the event strobe that downstream stages align to.

## Interface
- No parameters; widths are fixed (8-bit trigger word, 7-bit interval, 10-bit internal counter).
- `clk` — input, 1 bit. Single clock; all state changes on the rising edge.
- `rst` — input, 1 bit. Reset is synchronous and active-low, sampled on the rising edge of `clk`.
- `trg_wrd` — input, 8 bits. Head word of the timing FIFO. Valid whenever `fifo_empty` = 0.
  - Bits [6:0]: interval N, in cycles.
  - Bit [7]: coarse-scale flag (see Configuration).
- `fifo_empty` — input, 1 bit. 1 means the FIFO holds no word.
- `re` — output, 1 bit, registered. One-cycle pop/event strobe to the FIFO.

## Operation
- Four states:
  - IDLE: waiting for a word.
  - WAIT: counting down the interval.
  - FIRE: `re` = 1.
  - GAP: lets the FIFO update its head word and empty flag.
- IDLE:
  - If `fifo_empty` = 0 at an edge, latch `trg_wrd`, load `cnt` = E, go to WAIT.
  - Otherwise stay in IDLE.
- Effective interval E:
  - With the coarse feature: E = N when bit 7 = 0, and E = 8·N when bit 7 = 1.
  - Without the coarse feature: E = N.
- WAIT:
  - If `cnt` ≠ 0, decrement by 1 each edge.
  - If `cnt` = 0, go to FIRE.
- FIRE → GAP → IDLE, unconditionally, one cycle each.
- `re` = 1 exactly while in FIRE, and 0 in every other state.
- The word is latched at acceptance. `trg_wrd` and `fifo_empty` are ignored in WAIT, FIRE and GAP; changes there have no effect.
- This unit is the only reader of the FIFO, so the FIFO cannot go empty between acceptance and FIRE. `re` is not gated by `fifo_empty`.
- N = 0 is legal: the unit fires on the edge after acceptance.
- `cnt` is 10 bits; the maximum E is 8·127 = 1016, so there is no wrap.

## Timing
- Reset (`rst` = 0 at an edge):
  - State goes to IDLE; `cnt` = 0; `re` = 0; the latched word = 0.
  - This happens regardless of the current state, including mid-WAIT and during FIRE. The pending word is not popped and is re-accepted after reset.
- Latency: a word accepted at edge k gives `re` = 1 for the single cycle following edge k+E+1.
- Throughput: with words continuously available, successive `re` pulses are spaced E+4 cycles apart (accept, E+1 cycles in WAIT, FIRE, GAP).
- `re` is never asserted on two consecutive cycles.
- The first edge with `rst` = 1 after reset may accept a word.

## Configuration
- Macro: `TCU_COARSE_SCALE_EN`.
- Defined: bit 7 of `trg_wrd` selects the ×8 interval prescale (E = 8·N).
- Undefined: bit 7 is ignored, E = N, and `cnt` may be reduced to 7 bits.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold `rst` = 0 for 2 edges with `fifo_empty` = 0 → `re` = 0 throughout and state is IDLE. Release → a word is accepted at the first edge with `rst` = 1.
- Interval: `trg_wrd` = 0x03 accepted at edge k → `re` = 1 only in the cycle after edge k+4. Next acceptance at edge k+7.
- Coarse: `trg_wrd` = 0x81 → `re` after edge k+9 with `TCU_COARSE_SCALE_EN` defined, and after edge k+2 without it.
- Zero interval, back-to-back: FIFO streams 0x00 words → `re` pulses every 4 cycles, each exactly 1 cycle wide.
- Empty: `fifo_empty` held at 1 for 20 cycles → `re` stays 0 and state stays IDLE. Deassert `fifo_empty` with `trg_wrd` = 0x02 → `re` 3 edges after acceptance.
- Reset mid-operation: accept 0x7F, then assert `rst` = 0 at the 10th WAIT cycle → no `re`, state is IDLE. After release, the same word restarts the full 127-cycle count.
